// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM pipeline blocks:
//   NOP_WORD_DEFAULT : word presented by the fetch stage when no valid fetch exists
//   ld_state_e       : program-loader FSM states
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

endpackage : arm_pkg

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Assembles a little-endian 32-bit word from a stream of bytes. Byte k of a
// word lands in bits [8k+7:8k]. A flush completes a partial word, padding the
// missing upper bytes with zero.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   i_clear      in   discard any partial word and restart at byte 0
//   i_byte_valid in   i_byte is to be accepted this cycle
//   i_byte       in   program byte
//   i_flush      in   emit the partial word (after accepting a same-cycle byte)
//   o_word       out  assembled word (valid when o_word_valid)
//   o_word_valid out  o_word must be written this cycle
//
// o_word/o_word_valid are combinational so the word is written on the same
// edge as its last byte (or the flush). This keeps the final word of a load
// in memory by the time the FSM leaves LOAD, so the first fetch sees it.
// -----------------------------------------------------------------------------
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_flush,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic [31:0] w_asm;
  logic [2:0]  w_cnt_next;

  // Insert the incoming byte into its lane and compute the post-accept count.
  always_comb begin
    w_asm      = {8'h00, r_buf};
    w_cnt_next = {1'b0, r_cnt};
    if (i_byte_valid) begin
      case (r_cnt)
        2'd0:    w_asm[7:0]   = i_byte;
        2'd1:    w_asm[15:8]  = i_byte;
        2'd2:    w_asm[23:16] = i_byte;
        2'd3:    w_asm[31:24] = i_byte;
        default: w_asm        = {8'h00, r_buf};
      endcase
      w_cnt_next = {1'b0, r_cnt} + 3'd1;
    end else begin
      w_asm      = {8'h00, r_buf};
      w_cnt_next = {1'b0, r_cnt};
    end
    o_word = w_asm;
    // Full word, or a flush with at least one byte collected; clear wins.
    o_word_valid = !i_clear &&
                   ((w_cnt_next == 3'd4) || (i_flush && (w_cnt_next != 3'd0)));
  end

  // Byte counter and partial-word buffer; zeroed after each emitted word so
  // the unused upper lanes are already zero-padded for a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_buf <= 24'h00_0000;
    end else if (i_clear || o_word_valid) begin
      r_cnt <= 2'd0;
      r_buf <= 24'h00_0000;
    end else begin
      r_cnt <= w_cnt_next[1:0];
      r_buf <= w_asm[23:0];
    end
  end

endmodule : byte_word_packer

// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
// Synchronous-read instruction memory for the IF stage with a byte-serial
// program loader. Fetch has one cycle of latency and honours freeze / flush.
//
// Parameters:
//   ADDR_WIDTH  word-address bits (depth = 2**ADDR_WIDTH words)
//   NOP_WORD    word presented when no valid fetch is available
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   pc               fetch byte address
//   freeze, flush    hold / squash the fetch outputs (flush wins)
//   instruction      fetched word
//   inst_valid       instruction is a real fetched word
//   misaligned       pc[1:0] was non-zero at fetch
//   out_of_range     pc was beyond the memory at fetch
//   load_start       enter LOAD, restart write pointer
//   load_byte_valid  load_byte valid this cycle
//   load_byte        program byte (little-endian within a word)
//   load_end         finish loading, go to RUN
//   load_busy        loader is in LOAD
//   load_overflow    sticky: bytes were dropped because memory was full
//   load_words       words written by the last / current load
// -----------------------------------------------------------------------------
module instr_mem_loadable
  import arm_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic                  freeze,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  output logic                  misaligned,
  output logic                  out_of_range,
  input  logic                  load_start,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_end,
  output logic                  load_busy,
  output logic                  load_overflow,
  output logic [ADDR_WIDTH:0]   load_words
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  ld_state_e r_state;
  ld_state_e w_state_next;

  logic [ADDR_WIDTH:0] r_wptr;
  logic                r_overflow;
  logic                r_busy;

  logic [31:0]         r_mem [0:DEPTH-1];
  logic [31:0]         r_rdata;
  logic                r_inst_valid;
  logic                r_misaligned;
  logic                r_out_of_range;

  logic                w_in_load;
  logic                w_full;
  logic                w_byte_ok;
  logic                w_flush_pack;
  logic [31:0]         w_word;
  logic                w_word_valid;
  logic                w_write;
  logic                w_oor_now;
  logic [ADDR_WIDTH-1:0] w_rd_idx;

  // Loader qualification: bytes are only taken in LOAD while there is room.
  always_comb begin
    w_in_load    = (r_state == LD_LOAD);
    w_full       = r_wptr[ADDR_WIDTH];
    w_byte_ok    = w_in_load && load_byte_valid && !w_full && !load_start;
    w_flush_pack = w_in_load && load_end && !load_start;
    w_write      = w_word_valid && !w_full;
    w_oor_now    = |(pc >> (ADDR_WIDTH + 2));
    w_rd_idx     = pc[ADDR_WIDTH+1:2];
  end

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (load_start),
    .i_byte_valid (w_byte_ok),
    .i_byte       (load_byte),
    .i_flush      (w_flush_pack),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Loader FSM next-state: load_start always (re)enters LOAD.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LD_IDLE: begin
        if (load_start) w_state_next = LD_LOAD;
        else            w_state_next = LD_IDLE;
      end
      LD_LOAD: begin
        if (load_start)    w_state_next = LD_LOAD;
        else if (load_end) w_state_next = LD_RUN;
        else               w_state_next = LD_LOAD;
      end
      LD_RUN: begin
        if (load_start) w_state_next = LD_LOAD;
        else            w_state_next = LD_RUN;
      end
      default: w_state_next = LD_IDLE;
    endcase
  end

  // Loader FSM state register and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LD_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == LD_LOAD);
    end
  end

  // Write pointer (doubles as the loaded-word count) and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else if (load_start) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      if (w_in_load && load_byte_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Memory write port; no reset so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= w_word;
    end
  end

  // Memory read register, enabled by !freeze; reset-free so it can be the
  // RAM's own output register. Its value is only exposed when inst_valid.
  always_ff @(posedge clk) begin
    if (!freeze) begin
      r_rdata <= r_mem[w_rd_idx];
    end
  end

  // Fetch status registers: flush squashes, freeze holds, LOAD inhibits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
    end else if (flush) begin
      r_inst_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
    end else if (freeze) begin
      r_inst_valid   <= r_inst_valid;
      r_misaligned   <= r_misaligned;
      r_out_of_range <= r_out_of_range;
    end else if (w_in_load) begin
      r_inst_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
    end else begin
      r_inst_valid   <= !w_oor_now;
      r_misaligned   <= (pc[1:0] != 2'b00);
      r_out_of_range <= w_oor_now;
    end
  end

  // Every case that must present NOP_WORD (reset, flush, LOAD, out of range)
  // also clears inst_valid, so the word is selected from registers only.
  always_comb begin
    instruction   = r_inst_valid ? r_rdata : NOP_WORD;
    inst_valid    = r_inst_valid;
    misaligned    = r_misaligned;
    out_of_range  = r_out_of_range;
    load_busy     = r_busy;
    load_overflow = r_overflow;
    load_words    = r_wptr;
  end

endmodule : instr_mem_loadable

// File: tb/tb_instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loadable
// Directed bench for instr_mem_loadable. Two instances share all inputs: the
// default-size memory and a 4-word memory (ADDR_WIDTH=2) for overflow cases.
// -----------------------------------------------------------------------------
module tb_instr_mem_loadable;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        freeze;
  logic        flush;
  logic        load_start;
  logic        load_byte_valid;
  logic [7:0]  load_byte;
  logic        load_end;

  logic [31:0] instruction,  instruction2;
  logic        inst_valid,   inst_valid2;
  logic        misaligned,   misaligned2;
  logic        out_of_range, out_of_range2;
  logic        load_busy,    load_busy2;
  logic        load_overflow, load_overflow2;
  logic [10:0] load_words;
  logic [2:0]  load_words2;

  int n_total;
  int n_bad;

  instr_mem_loadable #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .pc(pc), .freeze(freeze), .flush(flush),
    .instruction(instruction), .inst_valid(inst_valid),
    .misaligned(misaligned), .out_of_range(out_of_range),
    .load_start(load_start), .load_byte_valid(load_byte_valid),
    .load_byte(load_byte), .load_end(load_end),
    .load_busy(load_busy), .load_overflow(load_overflow),
    .load_words(load_words)
  );

  instr_mem_loadable #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .freeze(freeze), .flush(flush),
    .instruction(instruction2), .inst_valid(inst_valid2),
    .misaligned(misaligned2), .out_of_range(out_of_range2),
    .load_start(load_start), .load_byte_valid(load_byte_valid),
    .load_byte(load_byte), .load_end(load_end),
    .load_busy(load_busy2), .load_overflow(load_overflow2),
    .load_words(load_words2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte       = b;
    step();
    load_byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    step();
    load_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a;
    step();
  endtask

  logic [7:0] prog_bytes [0:7];
  logic [31:0] words2 [0:3];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; pc = 32'h0; freeze = 1'b0; flush = 1'b0;
    load_start = 1'b0; load_byte_valid = 1'b0; load_byte = 8'h00; load_end = 1'b0;
    prog_bytes[0] = 8'h14; prog_bytes[1] = 8'h00; prog_bytes[2] = 8'hA0; prog_bytes[3] = 8'hE3;
    prog_bytes[4] = 8'h01; prog_bytes[5] = 8'h1A; prog_bytes[6] = 8'hA0; prog_bytes[7] = 8'hE3;
    words2[0] = 32'h1312_1110; words2[1] = 32'h1716_1514;
    words2[2] = 32'h1B1A_1918; words2[3] = 32'h1F1E_1D1C;

    // Reset state
    step(); step();
    check_val("rst_instr",    instruction,            32'h0);
    check_val("rst_valid",    {31'd0, inst_valid},    32'd0);
    check_val("rst_busy",     {31'd0, load_busy},     32'd0);
    check_val("rst_ovf",      {31'd0, load_overflow}, 32'd0);
    check_val("rst_words",    {21'd0, load_words},    32'd0);
    check_val("rst_misal",    {31'd0, misaligned},    32'd0);
    rst = 1'b0;

    // IDLE fetch
    fetch(32'h0);
    check_val("idle_valid",   {31'd0, inst_valid},    32'd1);
    check_val("idle_busy",    {31'd0, load_busy},     32'd0);
    check_val("idle_words",   {21'd0, load_words},    32'd0);

    // Two-word load
    pulse_start();
    check_val("ld_busy_set",  {31'd0, load_busy},     32'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog_bytes[i]);
      if (i == 0) check_val("ld_fetch_inhib", {31'd0, inst_valid}, 32'd0);
    end
    pulse_end();
    check_val("ld_busy_clr",  {31'd0, load_busy},     32'd0);
    check_val("ld_words2",    {21'd0, load_words},    32'd2);
    fetch(32'h0);
    check_val("fetch_w0",     instruction,            32'hE3A0_0014);
    check_val("fetch_w0_v",   {31'd0, inst_valid},    32'd1);
    fetch(32'h4);
    check_val("fetch_w1",     instruction,            32'hE3A0_1A01);

    // Partial load; last byte arrives together with load_end
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    load_byte_valid = 1'b1; load_byte = 8'h03; load_end = 1'b1;
    step();
    load_byte_valid = 1'b0; load_end = 1'b0;
    check_val("part_words",   {21'd0, load_words},    32'd1);
    fetch(32'h0);
    check_val("part_w0",      instruction,            32'h0003_0201);

    // Misaligned and out-of-range
    fetch(32'h6);
    check_val("misal_instr",  instruction,            32'hE3A0_1A01);
    check_val("misal_flag",   {31'd0, misaligned},    32'd1);
    check_val("misal_valid",  {31'd0, inst_valid},    32'd1);
    fetch(32'h0000_1000);
    check_val("oor_flag",     {31'd0, out_of_range},  32'd1);
    check_val("oor_valid",    {31'd0, inst_valid},    32'd0);
    check_val("oor_instr",    instruction,            32'h0);
    check_val("oor_misal",    {31'd0, misaligned},    32'd0);

    // Freeze holds outputs while pc moves
    fetch(32'h4);
    freeze = 1'b1;
    fetch(32'h0);
    check_val("frz_instr_a",  instruction,            32'hE3A0_1A01);
    fetch(32'h8);
    check_val("frz_instr_b",  instruction,            32'hE3A0_1A01);
    fetch(32'h0000_1000);
    check_val("frz_instr_c",  instruction,            32'hE3A0_1A01);
    check_val("frz_valid",    {31'd0, inst_valid},    32'd1);
    check_val("frz_oor",      {31'd0, out_of_range},  32'd0);
    flush = 1'b1;
    step();
    check_val("flfrz_valid",  {31'd0, inst_valid},    32'd0);
    check_val("flfrz_instr",  instruction,            32'h0);
    check_val("flfrz_oor",    {31'd0, out_of_range},  32'd0);
    freeze = 1'b0; flush = 1'b0;

    // Overflow on the 4-word instance (20 bytes into 16 bytes of room)
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h10 + 8'(i));
    end
    pulse_end();
    check_val("ovf_words2",   {29'd0, load_words2},   32'd4);
    check_val("ovf_flag2",    {31'd0, load_overflow2}, 32'd1);
    check_val("big_words",    {21'd0, load_words},    32'd5);
    check_val("big_ovf",      {31'd0, load_overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      check_val("ovf_mem2",   instruction2,           words2[i]);
    end
    fetch(32'h10);
    check_val("oor2_flag",    {31'd0, out_of_range2}, 32'd1);
    pulse_start();
    check_val("rs_ovf2",      {31'd0, load_overflow2}, 32'd0);
    check_val("rs_words2",    {29'd0, load_words2},   32'd0);
    check_val("rs_busy2",     {31'd0, load_busy2},    32'd1);
    pulse_end();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_instr_mem_loadable

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, synchronous-read instruction memory for the ARM pipeline IF stage, with a byte-serial program loader. Programs are streamed in at run time rather than hard-coded, so one bitstream runs any test program. The fetch port has 1-cycle registered latency, honours the pipeline freeze and flush signals, and flags misaligned or out-of-range PCs. The block sits between the PC register and the IF/ID pipeline register.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth = 2^ADDR_WIDTH words (default 1024 words = 4 KiB).
- `NOP_WORD`, default 32'h0000_0000: word presented when no valid fetch is available.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  byte address of the fetch.
- freeze  in  1  hazard stall: hold the fetch output registers.
- flush  in  1  branch taken: squash the fetch output.
- instruction  out  32  fetched word, registered.
- inst_valid  out  1  instruction holds a real fetched word.
- misaligned  out  1  registered: pc[1:0] != 0 at fetch.
- out_of_range  out  1  registered: pc[31:ADDR_WIDTH+2] != 0 at fetch.
- load_start  in  1  pulse: enter LOAD and reset the write pointer to 0.
- load_byte_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte, little-endian within each word.
- load_end  in  1  pulse: finish loading.
- load_busy  out  1  FSM is in LOAD.
- load_overflow  out  1  sticky: bytes were dropped because the memory was full.
- load_words  out  ADDR_WIDTH+1  number of words written by the last or current load.

## Operation
- FSM states: IDLE → (load_start) LOAD → (load_end) RUN. In RUN, load_start → LOAD. In IDLE, fetch behaves as in RUN against the current (uninitialised) contents.
- Reset: state=IDLE; instruction=NOP_WORD; inst_valid, misaligned, out_of_range, load_busy, load_overflow = 0; load_words=0; byte counter and write pointer = 0. Memory array is not reset.
- Load assembly: a 2-bit byte counter and a 24-bit shift buffer.
  - Byte k of a word goes to bits [8k+7:8k].
  - On the 4th byte, the full word is written at wptr, then wptr and load_words increment.
  - If wptr == 2^ADDR_WIDTH, the byte is dropped and load_overflow is set.
- load_end with a partial word: missing bytes are padded with 0, the word is written, and the counter increments. A byte arriving in the same cycle as load_end is accepted first.
- load_start in LOAD: restarts the load (wptr=0, byte counter=0, load_words=0, load_overflow=0). The partial word is discarded.
- load_byte_valid outside LOAD is ignored.
- Fetch, when not freeze, in RUN/IDLE:
  - instruction ← mem[pc[ADDR_WIDTH+1:2]]; the low two PC bits are ignored for indexing.
  - inst_valid ← !out_of_range_now.
  - If out of range, instruction ← NOP_WORD.
- Fetch while in LOAD: instruction ← NOP_WORD, inst_valid ← 0.
- freeze=1: all fetch output registers hold.
- flush=1: instruction ← NOP_WORD, inst_valid ← 0, misaligned ← 0, out_of_range ← 0. Flush has priority over freeze.

## Timing
- Fetch latency: 1 cycle. A pc presented in cycle N appears on the outputs after edge N+1.
- Write-to-read: a word written at edge N is readable by a fetch sampled at edge N+1 or later. There is no same-edge bypass; this cannot occur, because fetch is inhibited in LOAD.
- load_busy is asserted the edge after load_start and cleared the edge after load_end. The first valid fetch can occur the cycle after load_end.
- Reset asserted mid-load: the block returns to IDLE immediately. Words already written remain in memory.

## Structure
- Shared package arm_pkg: `NOP_WORD` default, and the FSM state enum (`LD_IDLE`, `LD_LOAD`, `LD_RUN`).
- One sub-module, `byte_word_packer`: byte counter, shift buffer, zero-pad on flush, word_valid output. The top level holds the memory array, the FSM, the write pointer and the fetch registers.
- Memory is inferred as a single-port-write / single-port-read synchronous RAM, so it maps to block RAM.

## Test plan
- Reset then IDLE fetch: pc=0 → inst_valid=1 after 1 cycle, while load_busy=0 and load_words=0.
- Load E3A00014, E3A01A01 as bytes 14,00,A0,E3,01,1A,A0,E3, then load_end → load_words=2. Fetch pc=0 gives E3A00014; pc=4 gives E3A01A01.
- Partial load: bytes 01,02,03 then load_end → mem[0]=00030201 and load_words=1.
- pc=6 → instruction=mem[1] with misaligned=1. pc=32'h0000_1000 (default params) → out_of_range=1, inst_valid=0, instruction=0.
- freeze held 3 cycles while pc changes → outputs are constant. freeze=1 with flush=1 → inst_valid=0 and instruction=0.
- ADDR_WIDTH=2: stream 20 bytes → load_words=4, load_overflow=1, mem[0..3] intact. Then load_start → overflow clears and load_words=0.
